// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array slice: width derivation,
// default geometry and the drain sequencer state encoding.
package systolic_pkg;

  localparam int DEFAULT_ARRAY_SIZE = 16;
  localparam int DEFAULT_OUT_WIDTH  = 8;

  // Accumulator width: product width plus headroom for ARRAY_SIZE-deep sums.
  function automatic int outcome_width(input int data_width, input int weight_width);
    return data_width + weight_width + 5;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CAPTURE,
    WRITE,
    FINISH
  } drain_state_t;

endpackage

// File: rtl/systolic_requant.sv
// Single-lane requantizer: round half up, arithmetic right shift, saturate
// to a signed OUT_WIDTH result, flagging any clamp.
module systolic_requant #(
  parameter int IN_WIDTH  = 29,
  parameter int OUT_WIDTH = 8
) (
  input  logic [IN_WIDTH-1:0]  din,
  input  logic [4:0]           shift,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 sat
);

  // One extra bit so the rounding add cannot overflow.
  localparam int W = IN_WIDTH + 1;
  localparam logic signed [W-1:0] MAX_V = {{(W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_V = ~MAX_V;

  logic signed [W-1:0] ext;
  logic signed [W-1:0] rnd;
  logic signed [W-1:0] sum;
  logic signed [W-1:0] shd;

  always_comb begin
    ext = signed'({din[IN_WIDTH-1], din});
    rnd = '0;
    if (shift != 5'd0) begin
      rnd = W'(1) << (shift - 5'd1);
    end
    sum  = ext + rnd;
    shd  = sum >>> shift;
    sat  = 1'b0;
    dout = shd[OUT_WIDTH-1:0];
    if (shd > MAX_V) begin
      dout = MAX_V[OUT_WIDTH-1:0];
      sat  = 1'b1;
    end else if (shd < MIN_V) begin
      dout = MIN_V[OUT_WIDTH-1:0];
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/systolic_drain.sv
// Output drain for the systolic array: sweeps matrix_index, requantizes each
// captured row and writes it to the output SRAM over a valid/ready handshake.
module systolic_drain
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE   = DEFAULT_ARRAY_SIZE,
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 16,
  parameter int OUT_WIDTH    = DEFAULT_OUT_WIDTH,
  parameter int NUM_INDEX    = 32,
  parameter int ADDR_WIDTH   = 10,
  localparam int OUTCOME_WIDTH = outcome_width(DATA_WIDTH, WEIGHT_WIDTH)
) (
  input  logic                            clk,
  input  logic                            srstn,
  input  logic                            drain_start,
  input  logic [ADDR_WIDTH-1:0]           base_addr,
  input  logic [4:0]                      shift,
  input  logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] mul_outcome,
  output logic [5:0]                      matrix_index,
  output logic                            sram_wvalid,
  input  logic                            sram_wready,
  output logic [ADDR_WIDTH-1:0]           sram_waddr,
  output logic [ARRAY_SIZE*OUT_WIDTH-1:0] sram_wdata,
  output logic                            busy,
  output logic                            done,
  output logic                            sat_flag
);

  localparam int IDX_W = $clog2(NUM_INDEX);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INDEX - 1);

  drain_state_t                  state;
  logic [IDX_W-1:0]              idx;
  logic [ADDR_WIDTH-1:0]         base_q;
  logic [4:0]                    shift_q;
  logic [ARRAY_SIZE*OUT_WIDTH-1:0] lane_q;
  logic [ARRAY_SIZE-1:0]         lane_sat;

  for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
    systolic_requant #(
      .IN_WIDTH  (OUTCOME_WIDTH),
      .OUT_WIDTH (OUT_WIDTH)
    ) u_requant (
      .din   (mul_outcome[g*OUTCOME_WIDTH +: OUTCOME_WIDTH]),
      .shift (shift_q),
      .dout  (lane_q[g*OUT_WIDTH +: OUT_WIDTH]),
      .sat   (lane_sat[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state        <= IDLE;
      idx          <= '0;
      base_q       <= '0;
      shift_q      <= '0;
      matrix_index <= '0;
      sram_wvalid  <= 1'b0;
      sram_waddr   <= '0;
      sram_wdata   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sat_flag     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (drain_start) begin
            base_q       <= base_addr;
            shift_q      <= shift;
            idx          <= '0;
            matrix_index <= '0;
            sat_flag     <= 1'b0;
            busy         <= 1'b1;
            state        <= SETUP;
          end
        end
        SETUP: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          sram_wdata  <= lane_q;
          sram_waddr  <= base_q + ADDR_WIDTH'(idx);
          sram_wvalid <= 1'b1;
          if (|lane_sat) begin
            sat_flag <= 1'b1;
          end
          state <= WRITE;
        end
        WRITE: begin
          if (sram_wready) begin
            sram_wvalid <= 1'b0;
            if (idx == LAST_IDX) begin
              state <= FINISH;
            end else begin
              idx          <= idx + 1'b1;
              matrix_index <= 6'(idx) + 6'd1;
              state        <= SETUP;
            end
          end
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
